// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the access sequencer and data memory.
// The master side issues requests and the slave side returns read data and the acknowledge.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ack;

  modport master (
    output req, we, addr, wr_data,
    input  rd_data, ack
  );

  modport slave (
    input  req, we, addr, wr_data,
    output rd_data, ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle ldb/stb sequencer. It stalls fetch while a req/ack data-memory access is in flight
// and returns a registered load result. A timeout aborts the access and sets a sticky error.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [8:0]        i_instr,
  input  logic              i_instr_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  output logic              o_stall_c,
  output logic              o_load_done,
  output logic              o_store_done,
  output logic [DATA_W-1:0] o_mem_read_value,
  output logic              o_mem_error,
  mem_access_unit_if.master dmem
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT);
  localparam logic [3:0]  OP_LDB = 4'b1000;
  localparam logic [3:0]  OP_STB = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_req, w_req_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic [DATA_W-1:0] r_rd_value, w_rd_value_nxt;
  logic              r_load_done, w_load_done_nxt;
  logic              r_store_done, w_store_done_nxt;
  logic              r_err, w_err_nxt;

  logic w_is_store;
  logic w_mem_op;
  logic w_timeout;
  logic w_unused_instr_bits;

  assign w_is_store = (i_instr[8:5] == OP_STB);
  assign w_mem_op   = i_instr_valid && ((i_instr[8:5] == OP_LDB) || w_is_store);
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
  // Low instruction bits carry register fields that this unit never inspects.
  assign w_unused_instr_bits = &{1'b0, i_instr[4:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_rd_value   <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_cnt_nxt;
      r_req        <= w_req_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_rd_value   <= w_rd_value_nxt;
      r_load_done  <= w_load_done_nxt;
      r_store_done <= w_store_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state logic. The done pulses are registered on the REQ->DONE edge so they land in DONE.
  always_comb begin
    w_next_state     = r_state;
    w_cnt_nxt        = r_cnt;
    w_req_nxt        = r_req;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wr_data_nxt    = r_wr_data;
    w_rd_value_nxt   = r_rd_value;
    w_load_done_nxt  = 1'b0;
    w_store_done_nxt = 1'b0;
    w_err_nxt        = r_err;
    o_stall_c        = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_stall_c = w_mem_op;
        if (w_mem_op) begin
          w_addr_nxt = i_addr;
          w_we_nxt   = w_is_store;
          if (w_is_store) w_wr_data_nxt = i_store_data;
          w_req_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        o_stall_c = 1'b1;
        if (dmem.ack || w_timeout) begin
          // An ack in the final timeout cycle takes priority over the abort.
          if (!r_we) w_rd_value_nxt = dmem.ack ? dmem.rd_data : '1;
          if (!dmem.ack) w_err_nxt = 1'b1;
          w_req_nxt        = 1'b0;
          w_load_done_nxt  = !r_we;
          w_store_done_nxt = r_we;
          w_next_state     = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign o_load_done      = r_load_done;
  assign o_store_done     = r_store_done;
  assign o_mem_read_value = r_rd_value;
  assign o_mem_error      = r_err;
  assign dmem.req         = r_req;
  assign dmem.we          = r_we;
  assign dmem.addr        = r_addr;
  assign dmem.wr_data     = r_wr_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, timeout abort, reset mid-access
// and pass-through of non-memory instructions.
module tb_mem_access_unit;

  logic       clk;
  logic       reset;
  logic [8:0] instr;
  logic       instr_valid;
  logic [7:0] addr_in;
  logic [7:0] store_data;
  logic       stall;
  logic       load_done;
  logic       store_done;
  logic [7:0] mem_read_value;
  logic       mem_error;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit_if #(.DATA_W(8), .ADDR_W(8)) dmem_if ();

  mem_access_unit #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(16)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_instr          (instr),
    .i_instr_valid    (instr_valid),
    .i_addr           (addr_in),
    .i_store_data     (store_data),
    .o_stall_c        (stall),
    .o_load_done      (load_done),
    .o_store_done     (store_done),
    .o_mem_read_value (mem_read_value),
    .o_mem_error      (mem_error),
    .dmem             (dmem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d);
    instr       = {op, 5'b00011};
    instr_valid = 1'b1;
    addr_in     = a;
    store_data  = d;
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    instr           = '0;
    instr_valid     = 1'b0;
    addr_in         = '0;
    store_data      = '0;
    dmem_if.ack     = 1'b0;
    dmem_if.rd_data = '0;
    tick();
    tick();

    // Reset state
    chk("rst_req", 32'(dmem_if.req), 32'd0);
    chk("rst_we", 32'(dmem_if.we), 32'd0);
    chk("rst_addr", 32'(dmem_if.addr), 32'd0);
    chk("rst_wrdata", 32'(dmem_if.wr_data), 32'd0);
    chk("rst_mrv", 32'(mem_read_value), 32'd0);
    chk("rst_ld", 32'(load_done), 32'd0);
    chk("rst_sd", 32'(store_done), 32'd0);
    chk("rst_err", 32'(mem_error), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // 1: ldb, ack in first REQ cycle
    issue(4'b1000, 8'h3C, 8'h00);
    chk("t1_idle_stall", 32'(stall), 32'd1);
    chk("t1_idle_req", 32'(dmem_if.req), 32'd0);
    tick();
    instr_valid = 1'b0;
    dmem_if.ack = 1'b1;
    dmem_if.rd_data = 8'hA5;
    #1;
    chk("t1_req", 32'(dmem_if.req), 32'd1);
    chk("t1_addr", 32'(dmem_if.addr), 32'h3C);
    chk("t1_we", 32'(dmem_if.we), 32'd0);
    chk("t1_req_stall", 32'(stall), 32'd1);
    tick();
    dmem_if.ack = 1'b0;
    #1;
    chk("t1_ld", 32'(load_done), 32'd1);
    chk("t1_sd", 32'(store_done), 32'd0);
    chk("t1_mrv", 32'(mem_read_value), 32'hA5);
    chk("t1_done_req", 32'(dmem_if.req), 32'd0);
    chk("t1_done_stall", 32'(stall), 32'd0);
    tick();
    chk("t1_ld_pulse", 32'(load_done), 32'd0);

    // 2: stb, ack in the 4th REQ cycle
    issue(4'b1001, 8'h10, 8'h5A);
    chk("t2_idle_stall", 32'(stall), 32'd1);
    tick();
    instr_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      dmem_if.ack = (k == 4);
      #1;
      chk("t2_req", 32'(dmem_if.req), 32'd1);
      chk("t2_we", 32'(dmem_if.we), 32'd1);
      chk("t2_wrdata", 32'(dmem_if.wr_data), 32'h5A);
      chk("t2_addr", 32'(dmem_if.addr), 32'h10);
      chk("t2_stall", 32'(stall), 32'd1);
      tick();
    end
    dmem_if.ack = 1'b0;
    #1;
    chk("t2_sd", 32'(store_done), 32'd1);
    chk("t2_ld", 32'(load_done), 32'd0);
    chk("t2_mrv", 32'(mem_read_value), 32'hA5);
    chk("t2_stall_done", 32'(stall), 32'd0);
    chk("t2_err", 32'(mem_error), 32'd0);
    tick();

    // 3: ldb with no ack -> timeout after 16 REQ cycles
    issue(4'b1000, 8'h44, 8'h00);
    tick();
    instr_valid = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk("t3_req", 32'(dmem_if.req), 32'd1);
      chk("t3_ld_early", 32'(load_done), 32'd0);
      tick();
    end
    chk("t3_ld", 32'(load_done), 32'd1);
    chk("t3_err", 32'(mem_error), 32'd1);
    chk("t3_mrv", 32'(mem_read_value), 32'hFF);
    chk("t3_done_req", 32'(dmem_if.req), 32'd0);
    tick();
    chk("t3_err_sticky", 32'(mem_error), 32'd1);

    // Reset clears the sticky error
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t3_err_rst", 32'(mem_error), 32'd0);

    // 4: ack in the final timeout cycle
    issue(4'b1000, 8'h55, 8'h00);
    tick();
    instr_valid = 1'b0;
    dmem_if.rd_data = 8'hC3;
    for (int k = 0; k < 16; k++) begin
      dmem_if.ack = (k == 15);
      tick();
    end
    dmem_if.ack = 1'b0;
    #1;
    chk("t4_ld", 32'(load_done), 32'd1);
    chk("t4_err", 32'(mem_error), 32'd0);
    chk("t4_mrv", 32'(mem_read_value), 32'hC3);
    tick();

    // 5: reset in 2nd REQ cycle, ack the cycle after
    issue(4'b1000, 8'h66, 8'h00);
    tick();
    instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dmem_if.ack = 1'b1;
    dmem_if.rd_data = 8'h77;
    #1;
    chk("t5_req", 32'(dmem_if.req), 32'd0);
    chk("t5_mrv", 32'(mem_read_value), 32'd0);
    chk("t5_addr", 32'(dmem_if.addr), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);
    tick();
    dmem_if.ack = 1'b0;
    #1;
    chk("t5_ld", 32'(load_done), 32'd0);
    chk("t5_req2", 32'(dmem_if.req), 32'd0);
    chk("t5_mrv2", 32'(mem_read_value), 32'd0);

    // 6: ldb then add; stray ack in IDLE
    issue(4'b1000, 8'h20, 8'h00);
    tick();
    dmem_if.ack = 1'b1;
    dmem_if.rd_data = 8'h11;
    tick();
    dmem_if.ack = 1'b0;
    issue(4'b0000, 8'h30, 8'h99);
    chk("t6_done_stall", 32'(stall), 32'd0);
    chk("t6_mrv", 32'(mem_read_value), 32'h11);
    tick();
    dmem_if.ack = 1'b1;
    dmem_if.rd_data = 8'hEE;
    #1;
    chk("t6_add_stall", 32'(stall), 32'd0);
    chk("t6_add_req", 32'(dmem_if.req), 32'd0);
    tick();
    dmem_if.ack = 1'b0;
    #1;
    chk("t6_stray_req", 32'(dmem_if.req), 32'd0);
    chk("t6_stray_ld", 32'(load_done), 32'd0);
    chk("t6_stray_sd", 32'(store_done), 32'd0);
    chk("t6_stray_mrv", 32'(mem_read_value), 32'h11);
    chk("t6_addr_hold", 32'(dmem_if.addr), 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
